// File: rtl/recon_dma_ctrl_v2.sv
// recon_dma_ctrl_v2: reconfiguration controller on the app RX path.
// Parses the recon header in the first beat of each frame, keeps a small
// bitstream table, issues DMA read/write descriptors and realigns STORE
// payload so that the first payload byte lands on output byte 0.
module recon_dma_ctrl_v2 #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int HDR_OFFSET = 46,
  parameter int ADDR_WIDTH = 34,
  parameter int LEN_WIDTH  = 20,
  parameter int TAG_WIDTH  = 8,
  parameter int SLOTS      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_axis_rd_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_rd_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_rd_desc_tag,
  output logic                  m_axis_rd_desc_valid,
  input  logic                  m_axis_rd_desc_ready,
  output logic [ADDR_WIDTH-1:0] m_axis_wr_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_wr_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_wr_desc_tag,
  output logic                  m_axis_wr_desc_valid,
  input  logic                  m_axis_wr_desc_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  stat_store,
  output logic                  stat_load,
  output logic                  stat_err,
  output logic                  busy
);

  // P: first payload byte in the first beat; R: payload bytes carried by that beat.
  localparam int P   = HDR_OFFSET + 16;
  localparam int R   = KEEP_WIDTH - P;
  localparam int IDW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW  = LEN_WIDTH + 1;
  localparam int PCW = $clog2(KEEP_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, WR_DESC, RD_DESC, XFER, FLUSH, DROP} state_t;

  function automatic logic [PCW-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + PCW'(k[i]);
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic [IDW-1:0]         id_q;
  logic                   first_last_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [R*8-1:0]         resid_q;
  logic [R-1:0]           resid_keep_q;
  logic [CW-1:0]          cnt_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [SLOTS-1:0]       tbl_valid_q;
  logic [ADDR_WIDTH-1:0]  tbl_addr_q [SLOTS];
  logic [LEN_WIDTH-1:0]   tbl_len_q  [SLOTS];
  logic [DATA_WIDTH-1:0]  m_tdata_q;
  logic [KEEP_WIDTH-1:0]  m_tkeep_q;
  logic                   m_tvalid_q, m_tlast_q;
  logic                   stat_store_q, stat_load_q, stat_err_q;

  // Header fields, valid only while a first beat is presented in IDLE.
  logic [1:0]             hdr_op;
  logic [IDW-1:0]         hdr_id;
  logic [31:0]            hdr_len;
  logic [ADDR_WIDTH-1:0]  hdr_addr;
  logic                   len_ok, hdr_store_ok, hdr_load_ok, hdr_inval, hdr_bad;

  assign hdr_op   = s_axis_tdata[HDR_OFFSET*8 +: 2];
  assign hdr_id   = s_axis_tdata[(HDR_OFFSET+1)*8 +: IDW];
  assign hdr_len  = s_axis_tdata[(HDR_OFFSET+4)*8 +: 32];
  assign hdr_addr = s_axis_tdata[(HDR_OFFSET+8)*8 +: ADDR_WIDTH];

  assign len_ok       = (hdr_len != 32'd0) && ((hdr_len >> LEN_WIDTH) == 32'd0);
  assign hdr_store_ok = (hdr_op == 2'b00) && len_ok;
  assign hdr_load_ok  = (hdr_op == 2'b01) && tbl_valid_q[hdr_id];
  assign hdr_inval    = (hdr_op == 2'b10);
  assign hdr_bad      = !hdr_store_ok && !hdr_load_ok && !hdr_inval;

  logic          out_free, s_hs, idle_hs, wr_hs, rd_hs, xfer_load, flush_load, err_evt;
  logic [CW-1:0] cnt_sum;

  // The output register can take a new beat when empty or being drained.
  assign out_free   = !m_tvalid_q || m_axis_tready;
  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign idle_hs    = (state_q == IDLE) && s_hs;
  assign wr_hs      = m_axis_wr_desc_valid && m_axis_wr_desc_ready;
  assign rd_hs      = m_axis_rd_desc_valid && m_axis_rd_desc_ready;
  assign xfer_load  = (state_q == XFER) && s_hs;
  assign flush_load = (state_q == FLUSH) && out_free;
  assign cnt_sum    = cnt_q + CW'(popcnt(s_axis_tkeep));

  // Error sources: bad header, or payload byte count disagreeing with len at frame end.
  assign err_evt = (idle_hs && hdr_bad) ||
                   (wr_hs && first_last_q && (cnt_q != {1'b0, len_q})) ||
                   (xfer_load && s_axis_tlast && (cnt_sum != {1'b0, len_q}));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (s_hs) begin
        if (hdr_store_ok)     state_d = WR_DESC;
        else if (hdr_load_ok) state_d = RD_DESC;
        else                  state_d = s_axis_tlast ? IDLE : DROP;
      end
      WR_DESC: if (wr_hs) state_d = first_last_q ? FLUSH : XFER;
      RD_DESC: if (rd_hs) state_d = first_last_q ? IDLE : DROP;
      XFER:    if (s_hs && s_axis_tlast) state_d = s_axis_tkeep[P] ? FLUSH : IDLE;
      FLUSH:   if (out_free) state_d = IDLE;
      DROP:    if (s_hs && s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    s_axis_tready        = 1'b0;
    m_axis_wr_desc_valid = 1'b0;
    m_axis_rd_desc_valid = 1'b0;
    case (state_q)
      IDLE:    s_axis_tready = 1'b1;
      WR_DESC: m_axis_wr_desc_valid = 1'b1;
      RD_DESC: m_axis_rd_desc_valid = 1'b1;
      XFER:    s_axis_tready = out_free;
      DROP:    s_axis_tready = 1'b1;
      default: ;
    endcase
    busy = (state_q != IDLE);
  end

  // Control registers: event pulses, tag counter, table valid bits, output valid/last.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_store_q <= 1'b0;
      stat_load_q  <= 1'b0;
      stat_err_q   <= 1'b0;
      tag_q        <= '0;
      tbl_valid_q  <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      stat_store_q <= wr_hs;
      stat_load_q  <= rd_hs;
      stat_err_q   <= err_evt;
      if (wr_hs) tag_q <= tag_q + 1'b1;
      if (idle_hs && hdr_inval) tbl_valid_q[hdr_id] <= 1'b0;
      if (wr_hs) tbl_valid_q[id_q] <= 1'b1;
      if (m_axis_tready) m_tvalid_q <= 1'b0;
      if (xfer_load || flush_load) begin
        m_tvalid_q <= 1'b1;
        // Last beat closes here only when the new residual is empty.
        m_tlast_q  <= flush_load || (s_axis_tlast && !s_axis_tkeep[P]);
      end
    end
  end

  // Datapath: captured header, residual bytes, payload count and output beat.
  always_ff @(posedge clk) begin
    if (idle_hs) begin
      id_q         <= hdr_id;
      first_last_q <= s_axis_tlast;
      if (hdr_op == 2'b01) begin
        addr_q <= tbl_addr_q[hdr_id];
        len_q  <= tbl_len_q[hdr_id];
      end else begin
        addr_q <= hdr_addr;
        len_q  <= hdr_len[LEN_WIDTH-1:0];
      end
      resid_q      <= s_axis_tdata[DATA_WIDTH-1:P*8];
      resid_keep_q <= s_axis_tkeep[KEEP_WIDTH-1:P];
      cnt_q        <= CW'(popcnt({{P{1'b0}}, s_axis_tkeep[KEEP_WIDTH-1:P]}));
    end
    if (xfer_load) begin
      m_tdata_q    <= {s_axis_tdata[P*8-1:0], resid_q};
      m_tkeep_q    <= {s_axis_tkeep[P-1:0], resid_keep_q};
      resid_q      <= s_axis_tdata[DATA_WIDTH-1:P*8];
      resid_keep_q <= s_axis_tkeep[KEEP_WIDTH-1:P];
      cnt_q        <= cnt_sum;
    end
    if (flush_load) begin
      m_tdata_q <= {{(P*8){1'b0}}, resid_q};
      m_tkeep_q <= {{P{1'b0}}, resid_keep_q};
    end
  end

  // Bitstream table contents, written when a STORE descriptor is accepted.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      tbl_addr_q[id_q] <= addr_q;
      tbl_len_q[id_q]  <= len_q;
    end
  end

  assign m_axis_wr_desc_addr = addr_q;
  assign m_axis_wr_desc_len  = len_q;
  assign m_axis_wr_desc_tag  = tag_q;
  assign m_axis_rd_desc_addr = addr_q;
  assign m_axis_rd_desc_len  = len_q;
  assign m_axis_rd_desc_tag  = tag_q;
  assign m_axis_tdata        = m_tdata_q;
  assign m_axis_tkeep        = m_tkeep_q;
  assign m_axis_tvalid       = m_tvalid_q;
  assign m_axis_tlast        = m_tlast_q;
  assign stat_store          = stat_store_q;
  assign stat_load           = stat_load_q;
  assign stat_err            = stat_err_q;

endmodule
